// File: rtl/osd_pkg.sv
// Shared command/state types and constants for the OSD character-RAM writer.
package osd_pkg;

    typedef enum logic [1:0] {
        OSD_NOP    = 2'd0,
        OSD_CLEAR  = 2'd1,
        OSD_SETPOS = 2'd2,
        OSD_PUTC   = 2'd3
    } osd_cmd_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } osd_wr_state_e;

    localparam logic [7:0] OSD_CHAR_NL = 8'h0A;

endpackage

// File: rtl/osd_cursor.sv
// Row/column cursor with a linear cell address kept in step, so a write can use
// the address directly without a multiply on the write path.
module osd_cursor
    import osd_pkg::*;
#(
    parameter  int ADDR_WIDTH = 11,
    parameter  int COLS       = 40,
    parameter  int ROWS       = 30,
    localparam int COL_W      = $clog2(COLS),
    localparam int ROW_W      = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  zero,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  newline,
    input  logic [ROW_W-1:0]      load_row,
    input  logic [COL_W-1:0]      load_col,
    output logic [ROW_W-1:0]      row,
    output logic [COL_W-1:0]      col,
    output logic [ADDR_WIDTH-1:0] lin_addr
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic [ROW_W-1:0]      row_r, row_n_s;
    logic [COL_W-1:0]      col_r, col_n_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_n_s;

    // Next cursor position; operations are mutually exclusive, zero wins.
    always_comb begin
        row_n_s  = row_r;
        col_n_s  = col_r;
        addr_n_s = addr_r;
        if (zero) begin
            row_n_s  = {ROW_W{1'b0}};
            col_n_s  = {COL_W{1'b0}};
            addr_n_s = {ADDR_WIDTH{1'b0}};
        end else if (load) begin
            row_n_s  = (load_row > LAST_ROW) ? LAST_ROW : load_row;
            col_n_s  = (load_col > LAST_COL) ? LAST_COL : load_col;
            addr_n_s = ADDR_WIDTH'(row_n_s) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(col_n_s);
        end else if (advance) begin
            if (col_r == LAST_COL) begin
                col_n_s = {COL_W{1'b0}};
                if (row_r == LAST_ROW) begin
                    row_n_s  = {ROW_W{1'b0}};
                    addr_n_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    row_n_s  = row_r + ROW_W'(1);
                    addr_n_s = addr_r + ADDR_WIDTH'(1);
                end
            end else begin
                col_n_s  = col_r + COL_W'(1);
                addr_n_s = addr_r + ADDR_WIDTH'(1);
            end
        end else if (newline) begin
            col_n_s = {COL_W{1'b0}};
            if (row_r == LAST_ROW) begin
                row_n_s  = {ROW_W{1'b0}};
                addr_n_s = {ADDR_WIDTH{1'b0}};
            end else begin
                row_n_s  = row_r + ROW_W'(1);
                addr_n_s = ADDR_WIDTH'(row_n_s) * ADDR_WIDTH'(COLS);
            end
        end else begin
            row_n_s  = row_r;
            col_n_s  = col_r;
            addr_n_s = addr_r;
        end
    end

    // Cursor registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_r  <= {ROW_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            row_r  <= row_n_s;
            col_r  <= col_n_s;
            addr_r <= addr_n_s;
        end
    end

    assign row      = row_r;
    assign col      = col_r;
    assign lin_addr = addr_r;

endmodule

// File: rtl/osd_char_writer.sv
// Command-driven write controller for the OSD character RAM write port.
// Optional macro OSD_NEWLINE_EN: PUTC of 8'h0A moves to the next row instead of writing.
module osd_char_writer
    import osd_pkg::*;
#(
    parameter  int ADDR_WIDTH = 11,
    parameter  int DATA_WIDTH = 8,
    parameter  int COLS       = 40,
    parameter  int ROWS       = 30,
    localparam int COL_W      = $clog2(COLS),
    localparam int ROW_W      = $clog2(ROWS),
    localparam int NCELLS     = COLS * ROWS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_char,
    input  logic [ROW_W-1:0]      cmd_row,
    input  logic [COL_W-1:0]      cmd_col,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic                  busy,
    output logic                  done,
    output logic [ROW_W-1:0]      cursor_row,
    output logic [COL_W-1:0]      cursor_col
);

    generate
        if (COLS * ROWS > 2 ** ADDR_WIDTH) begin : g_size_check
            $error("osd_char_writer: COLS*ROWS does not fit in ADDR_WIDTH");
        end
    endgenerate

    localparam logic [0:0]            S_IDLE    = ST_IDLE;
    localparam logic [0:0]            S_CLEAR   = ST_CLEAR;
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(NCELLS - 1);

    logic [0:0]            state_r;
    logic                  we_r, busy_r, done_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;

    logic                  accept_s, clear_start_s, put_s, clear_last_s;
    logic                  cur_load_s, cur_adv_s, cur_nl_s;
    logic [ADDR_WIDTH-1:0] cur_addr_s;

    assign cmd_ready    = (state_r == S_IDLE);
    assign accept_s     = cmd_valid && cmd_ready;
    assign clear_last_s = (state_r == S_CLEAR) && (addr_r == LAST_CELL);

    // Decode an accepted command into a write request and a cursor operation.
    always_comb begin
        clear_start_s = 1'b0;
        put_s         = 1'b0;
        cur_load_s    = 1'b0;
        cur_adv_s     = 1'b0;
        cur_nl_s      = 1'b0;
        if (accept_s) begin
            case (cmd_op)
                OSD_CLEAR:  clear_start_s = 1'b1;
                OSD_SETPOS: cur_load_s    = 1'b1;
                OSD_PUTC: begin
`ifdef OSD_NEWLINE_EN
                    if (cmd_char == DATA_WIDTH'(OSD_CHAR_NL)) begin
                        cur_nl_s = 1'b1;
                    end else begin
                        put_s     = 1'b1;
                        cur_adv_s = 1'b1;
                    end
`else
                    put_s     = 1'b1;
                    cur_adv_s = 1'b1;
`endif
                end
                default: begin
                    put_s = 1'b0;
                end
            endcase
        end else begin
            put_s = 1'b0;
        end
    end

    osd_cursor #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .COLS       (COLS),
        .ROWS       (ROWS)
    ) u_cursor (
        .clk      (clk),
        .reset_n  (reset_n),
        .zero     (clear_last_s),
        .load     (cur_load_s),
        .advance  (cur_adv_s),
        .newline  (cur_nl_s),
        .load_row (cmd_row),
        .load_col (cmd_col),
        .row      (cursor_row),
        .col      (cursor_col),
        .lin_addr (cur_addr_s)
    );

    // FSM and registered RAM port; data_r doubles as the latched fill character.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (clear_start_s) begin
                        state_r <= S_CLEAR;
                        busy_r  <= 1'b1;
                        we_r    <= 1'b1;
                        addr_r  <= {ADDR_WIDTH{1'b0}};
                        data_r  <= cmd_char;
                    end else if (put_s) begin
                        we_r   <= 1'b1;
                        addr_r <= cur_addr_s;
                        data_r <= cmd_char;
                    end else begin
                        we_r <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (clear_last_s) begin
                        state_r <= S_IDLE;
                        we_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        we_r   <= 1'b1;
                        addr_r <= addr_r + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign we_a   = we_r;
    assign addr_a = addr_r;
    assign data_a = data_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule
